morse_code_decoder: RTL and testbench
=====================================

MORSE_CODE_DECODER -- requirements
Module: morse_code_decoder

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 25_000_000, giving one Morse time unit (dot length) in clk cycles; minimum legal value 4.
REQ-002 SHALL have port clk  input  1  system clock (100 MHz); all flops on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port morse_in  input  1  asynchronous Morse line; 1 = mark (LED on), 0 = space.
REQ-005 SHALL have port digit_out  output  4  last decoded digit 0-9; held until next valid.
REQ-006 SHALL have port valid  output  1  one-cycle pulse: digit_out updated this cycle.
REQ-007 SHALL have port error  output  1  one-cycle pulse: character rejected.
REQ-008 SHALL have port busy  output  1  high while a character is in progress (any state except IDLE).

Function
REQ-009 SHALL pass morse_in through a 2-flop synchronizer; all timing is measured on the synchronized signal (U = UNIT_CYCLES, L = mark length, S = space length, in cycles).
REQ-010 SHALL implement states IDLE, MARK, SPACE, DECODE, WAIT_LOW.
REQ-011 IDLE -> MARK on synchronized rising edge; mark counter starts at 1.
REQ-012 On falling edge in MARK: L < U/2 -> glitch, discarded, no symbol stored; go to IDLE if symbol count = 0, else to SPACE with space counter cleared.
REQ-013 U/2 <= L < 2U -> dot (bit 0); 2U <= L <= 4U -> dash (bit 1); the bit is shifted into a 5-bit register, first symbol ending in the MSB.
REQ-014 If mark counter reaches 4U+1 while the line is still high: pulse error, clear symbols, go to WAIT_LOW; WAIT_LOW -> IDLE on first synchronized low.
REQ-015 After the 5th symbol is stored: go to DECODE; otherwise go to SPACE.
REQ-016 In SPACE, rising edge -> MARK; if the space counter reaches 3U before the 5th symbol: pulse error, clear symbols, go to IDLE.
REQ-017 DECODE maps 11111->0, 01111->1, 00111->2, 00011->3, 00001->4, 00000->5, 10000->6, 11000->7, 11100->8, 11110->9; on match, load digit_out and pulse valid; any other code pulses error with digit_out unchanged; next state IDLE.
REQ-018 valid/error SHALL assert exactly one cycle after the FSM detects the synchronized falling edge of the 5th mark; valid and error are never high together.
REQ-019 Counters SHALL saturate and be wide enough for 4U+1 ($clog2); no wrap-around is permitted.
REQ-020 A new character SHALL be accepted from IDLE immediately after DECODE; no minimum inter-character gap is enforced.

Reset
REQ-021 While rst = 0: state IDLE, digit_out = 0, valid = 0, error = 0, busy = 0, symbol register, counters and synchronizer cleared.
REQ-022 Reset asserted mid-character SHALL discard the partial character with no valid or error pulse; after release the line is decoded from the next rising edge.

Structure
REQ-023 The shared package morse_pkg SHALL hold UNIT_CYCLES default, the 10-entry digit/code table (shared with the encoder) and the state encodings.
REQ-024 The synchronizer plus edge detector SHALL be the single sub-module morse_sync (outputs level, rise, fall).

Verification (UNIT_CYCLES = 10)
REQ-025 Marks 10,10,10,30,30 separated by 10-cycle spaces -> one valid pulse, digit_out = 3, error never high.
REQ-026 Five 30-cycle marks -> digit_out = 0; then five 10-cycle marks -> digit_out = 5; one valid per character.
REQ-027 3-cycle pulse inserted in the gap between the symbols of digit 7 -> ignored, digit_out = 7, no error.
REQ-028 Two dots, then line low for 40 cycles -> error pulses 30 cycles after the 2nd fall, busy drops; no valid.
REQ-029 Mark held high for 60 cycles -> error at count 41, WAIT_LOW until low; next digit 9 decodes correctly.
REQ-030 rst pulsed low after 3 symbols -> all outputs 0 with no pulse; subsequent digit 1 -> valid, digit_out = 1.

Source files
------------

// File: rtl/morse_pkg.sv
// Morse digit decoder shared definitions.
// Code table is shared with the encoder side.
package morse_pkg;

  localparam int UNIT_CYCLES_DEF = 25_000_000;
  localparam int NUM_DIGITS      = 10;

  // Index = digit; first symbol sent sits in bit 4, 1 = dash.
  localparam logic [9:0][4:0] CODE_TABLE = {
    5'b11110,
    5'b11100,
    5'b11000,
    5'b10000,
    5'b00000,
    5'b00001,
    5'b00011,
    5'b00111,
    5'b01111,
    5'b11111
  };

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MARK     = 3'd1,
    SPACE    = 3'd2,
    DECODE   = 3'd3,
    WAIT_LOW = 3'd4
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] digit;
  } lookup_t;

  function automatic lookup_t code_lookup(
    input logic [4:0] code
  );
    lookup_t r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (code == CODE_TABLE[i]) begin
        r.hit   = 1'b1;
        r.digit = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/morse_code_decoder_sync.sv
// Two-flop synchronizer for the Morse line
// plus rising/falling edge detection.
module morse_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  // Metastability chain and one-cycle history for edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~prev;
  assign fall  = ~s2 & prev;

endmodule

// File: rtl/morse_code_decoder.sv
// Morse digit decoder: times marks/spaces on the
// synchronized line and decodes 5-symbol digits.
module morse_code_decoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = UNIT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       morse_in,
  output logic [3:0] digit_out,
  output logic       valid,
  output logic       error,
  output logic       busy
);

  localparam int MARK_MAX = 4 * UNIT_CYCLES + 1;
  localparam int CNT_W    = $clog2(MARK_MAX + 1);

  localparam logic [CNT_W-1:0] HALF_U =
    CNT_W'(UNIT_CYCLES / 2);
  localparam logic [CNT_W-1:0] TWO_U =
    CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] FOUR_U =
    CNT_W'(4 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] MARK_SAT =
    CNT_W'(MARK_MAX);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_SAT =
    CNT_W'(3 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  logic level;
  logic rise;
  logic fall;

  morse_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (morse_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] mark_q;
  logic [CNT_W-1:0] mark_d;
  logic [CNT_W-1:0] space_q;
  logic [CNT_W-1:0] space_d;
  logic [3:0]       sym_q;
  logic [3:0]       sym_d;
  logic [2:0]       nsym_q;
  logic [2:0]       nsym_d;
  logic [3:0]       digit_q;
  logic [3:0]       digit_d;
  logic             valid_q;
  logic             valid_d;
  logic             error_q;
  logic             error_d;

  logic             is_dash;
  logic             is_glitch;
  logic [4:0]       code;
  lookup_t          hit;

  assign is_dash   = mark_q >= TWO_U;
  assign is_glitch = mark_q < HALF_U;
  assign code      = {sym_q, is_dash};
  assign hit       = code_lookup(code);

  // State, counters, symbols and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mark_q  <= '0;
      space_q <= '0;
      sym_q   <= '0;
      nsym_q  <= '0;
      digit_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mark_q  <= mark_d;
      space_q <= space_d;
      sym_q   <= sym_d;
      nsym_q  <= nsym_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  // Next state; the 5th symbol is decoded on its
  // falling edge so the pulse lands one cycle later.
  always_comb begin
    state_d = state_q;
    mark_d  = mark_q;
    space_d = space_q;
    sym_d   = sym_q;
    nsym_d  = nsym_q;
    digit_d = digit_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MARK;
          mark_d  = ONE;
        end
      end
      MARK: begin
        if (fall) begin
          space_d = '0;
          if (is_glitch) begin
            state_d = (nsym_q == 3'd0) ? IDLE : SPACE;
          end else if (nsym_q == 3'd4) begin
            state_d = DECODE;
            sym_d   = '0;
            nsym_d  = '0;
            if (hit.hit) begin
              digit_d = hit.digit;
              valid_d = 1'b1;
            end else begin
              error_d = 1'b1;
            end
          end else begin
            state_d = SPACE;
            sym_d   = code[3:0];
            nsym_d  = nsym_q + 3'd1;
          end
        end else if (mark_q >= FOUR_U) begin
          state_d = WAIT_LOW;
          mark_d  = MARK_SAT;
          sym_d   = '0;
          nsym_d  = '0;
          error_d = 1'b1;
        end else begin
          mark_d = mark_q + ONE;
        end
      end
      SPACE: begin
        if (rise) begin
          state_d = MARK;
          mark_d  = ONE;
        end else if (space_q >= GAP_LAST) begin
          state_d = IDLE;
          space_d = GAP_SAT;
          sym_d   = '0;
          nsym_d  = '0;
          error_d = 1'b1;
        end else begin
          space_d = space_q + ONE;
        end
      end
      DECODE: begin
        state_d = IDLE;
      end
      WAIT_LOW: begin
        if (!level) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign digit_out = digit_q;
  assign valid     = valid_q;
  assign error     = error_q;
  assign busy      = state_q != IDLE;

endmodule

// File: tb/tb_morse_code_decoder.sv
// Scoreboard bench for morse_code_decoder,
// one Morse unit = 10 clock cycles.
module tb_morse_code_decoder;

  localparam int U = 10;

  logic       clk;
  logic       rst;
  logic       morse_in;
  logic [3:0] digit_out;
  logic       valid;
  logic       error;
  logic       busy;

  morse_code_decoder #(
    .UNIT_CYCLES (U)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .morse_in  (morse_in),
    .digit_out (digit_out),
    .valid     (valid),
    .error     (error),
    .busy      (busy)
  );

  typedef struct {
    logic       is_err;
    logic [3:0] digit;
  } exp_t;

  exp_t       sbq[$];
  int         errors;
  int         checks;
  int         cyc;
  int         fall_cyc;
  int         rise_cyc;
  int         pulse_cyc;
  logic [3:0] last_digit;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_code(
    input int d
  );
    case (d)
      0: return 5'b11111;
      1: return 5'b01111;
      2: return 5'b00111;
      3: return 5'b00011;
      4: return 5'b00001;
      5: return 5'b00000;
      6: return 5'b10000;
      7: return 5'b11000;
      8: return 5'b11100;
      default: return 5'b11110;
    endcase
  endfunction

  task automatic push_ok(input int d);
    exp_t e;
    e.is_err   = 1'b0;
    e.digit    = 4'(d);
    last_digit = 4'(d);
    sbq.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.digit  = last_digit;
    sbq.push_back(e);
  endtask

  task automatic gap(input int n);
    morse_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic mark(input int n);
    morse_in = 1'b1;
    rise_cyc = cyc;
    repeat (n) @(negedge clk);
    morse_in = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic send_code(input logic [4:0] c);
    for (int i = 4; i >= 0; i--) begin
      mark(c[i] ? 3 * U : U);
      if (i > 0) gap(U);
    end
  endtask

  // Pop one expectation per valid/error pulse.
  always @(negedge clk) begin
    if (rst && (valid || error)) begin
      pulse_cyc = cyc;
      check("excl", 32'(valid & error), 0);
      if (sbq.size() == 0) begin
        check("unexp", 32'({valid, error}), 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("kind", 32'(error), 32'(e.is_err));
        check("digit", 32'(digit_out),
              32'(e.digit));
      end
    end
  end

  initial begin
    errors     = 0;
    checks     = 0;
    cyc        = 0;
    fall_cyc   = 0;
    rise_cyc   = 0;
    pulse_cyc  = 0;
    last_digit = 4'd0;
    rst        = 1'b0;
    morse_in   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_digit", 32'(digit_out), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_error", 32'(error), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    gap(5);

    // Digit 3, with pulse latency from line fall.
    push_ok(3);
    send_code(ref_code(3));
    gap(2 * U);
    check("lat_valid", 32'(pulse_cyc - fall_cyc), 3);
    check("pend_3", 32'(sbq.size()), 0);
    check("busy_idle", 32'(busy), 0);

    // Five dashes then five dots, back to back.
    push_ok(0);
    send_code(ref_code(0));
    gap(2 * U);
    push_ok(5);
    send_code(ref_code(5));
    gap(2 * U);
    check("pend_05", 32'(sbq.size()), 0);

    // Digit 7 with a 3-cycle glitch in a gap.
    push_ok(7);
    mark(3 * U);
    gap(U);
    mark(3 * U);
    gap(4);
    mark(3);
    gap(4);
    mark(U);
    gap(U);
    mark(U);
    gap(U);
    mark(U);
    gap(2 * U);
    check("pend_7", 32'(sbq.size()), 0);

    // Two dots then a long space: timeout.
    push_err();
    mark(U);
    gap(U);
    check("busy_mid", 32'(busy), 1);
    mark(U);
    gap(4 * U);
    check("lat_space", 32'(pulse_cyc - fall_cyc), 33);
    check("busy_tmo", 32'(busy), 0);
    check("pend_tmo", 32'(sbq.size()), 0);

    // Overlong mark: error, wait for low, digit 9.
    push_err();
    mark(6 * U);
    check("lat_long", 32'(pulse_cyc - rise_cyc), 43);
    gap(2 * U);
    check("busy_wl", 32'(busy), 0);
    push_ok(9);
    send_code(ref_code(9));
    gap(2 * U);
    check("pend_9", 32'(sbq.size()), 0);

    // Unknown code: error, digit held.
    push_err();
    send_code(5'b10101);
    gap(2 * U);
    check("hold_dig", 32'(digit_out), 9);
    check("pend_bad", 32'(sbq.size()), 0);

    // Reset after three symbols of digit 1.
    mark(U);
    gap(U);
    mark(3 * U);
    gap(U);
    mark(3 * U);
    gap(5);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mr_digit", 32'(digit_out), 0);
    check("mr_valid", 32'(valid), 0);
    check("mr_error", 32'(error), 0);
    check("mr_busy", 32'(busy), 0);
    rst        = 1'b1;
    last_digit = 4'd0;
    gap(U);
    push_ok(1);
    send_code(ref_code(1));
    gap(2 * U);
    check("pend_1", 32'(sbq.size()), 0);
    check("fin_dig", 32'(digit_out), 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
